// File: rtl/hms_timekeeper.sv
// rtl/hms_timekeeper.sv - 1 Hz sec/min/hour time-of-day core with plus/minus field edits.
// Optional TWELVE_HOUR_EN maps the hours output to 1..12 and drives pm.
module hms_timekeeper #(
    parameter int CLK_HZ = 50_000_000,
    localparam int PS_W = $clog2(CLK_HZ)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [2:0] select,
    input  logic       plus,
    input  logic       minus,
    output logic [5:0] secs,
    output logic [5:0] mins,
    output logic [5:0] hours,
    output logic       pm,
    output logic       tick_1hz
);

    logic [PS_W-1:0] ps;
    logic            tick_r;
    logic            pending;
    logic [5:0]      sec_r;
    logic [5:0]      min_r;
    logic [5:0]      hr_r;

    logic sel_onehot;
    logic edit_valid;
    logic edit_secs;
    logic ps_wrap;
    logic adv;

    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max_v,
                                              input logic up);
        if (up)
            return (v == max_v) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? max_v : v - 6'd1;
    endfunction

    assign sel_onehot = (select == 3'b001) || (select == 3'b010) || (select == 3'b100);
    assign edit_valid = sel_onehot && (plus ^ minus);
    assign edit_secs  = edit_valid && select[0];
    assign ps_wrap    = run && (ps == PS_W'(CLK_HZ - 1));
    assign adv        = tick_r | pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps       <= '0;
            tick_r   <= 1'b0;
            pending  <= 1'b0;
            tick_1hz <= 1'b0;
            sec_r    <= 6'd0;
            min_r    <= 6'd0;
            hr_r     <= 6'd0;
        end else begin
            // A seconds edit restarts the period, so a wrap in that same cycle is discarded.
            if (edit_secs)
                ps <= '0;
            else if (run)
                ps <= ps_wrap ? '0 : ps + PS_W'(1);
            tick_r <= ps_wrap && !edit_secs;

            if (edit_valid) begin
                // Edits win the cycle; any due second waits in pending (at most one).
                pending  <= adv;
                tick_1hz <= 1'b0;
                case (select)
                    3'b001:  sec_r <= step_field(sec_r, 6'd59, plus);
                    3'b010:  min_r <= step_field(min_r, 6'd59, plus);
                    3'b100:  hr_r  <= step_field(hr_r, 6'd23, plus);
                    default: ;
                endcase
            end else if (adv) begin
                pending  <= 1'b0;
                tick_1hz <= 1'b1;
                if (sec_r == 6'd59) begin
                    sec_r <= 6'd0;
                    if (min_r == 6'd59) begin
                        min_r <= 6'd0;
                        hr_r  <= (hr_r == 6'd23) ? 6'd0 : hr_r + 6'd1;
                    end else begin
                        min_r <= min_r + 6'd1;
                    end
                end else begin
                    sec_r <= sec_r + 6'd1;
                end
            end else begin
                tick_1hz <= 1'b0;
            end
        end
    end

    assign secs = sec_r;
    assign mins = min_r;

`ifdef TWELVE_HOUR_EN
    always_comb begin
        hours = hr_r;
        if (hr_r == 6'd0)
            hours = 6'd12;
        else if (hr_r > 6'd12)
            hours = hr_r - 6'd12;
    end
    assign pm = (hr_r >= 6'd12);
`else
    assign hours = hr_r;
    assign pm    = 1'b0;
`endif

endmodule

// File: tb/tb_hms_timekeeper.sv
// tb/tb_hms_timekeeper.sv - randomized bench for hms_timekeeper against a seconds-of-day model.
module tb_hms_timekeeper;

    localparam int CLK_HZ = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic [2:0] select;
    logic       plus;
    logic       minus;
    logic [5:0] secs;
    logic [5:0] mins;
    logic [5:0] hours;
    logic       pm;
    logic       tick_1hz;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt = 0;

    hms_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .select(select), .plus(plus), .minus(minus),
        .secs(secs), .mins(mins), .hours(hours), .pm(pm), .tick_1hz(tick_1hz)
    );

    always #5 clk = ~clk;

    // Model: time as seconds of day, prescaler phase, tick due from last wrap, pending count.
    int m_t, m_ps, m_due, m_pend, m_tick;
    int n_t, n_ps, n_due, n_pend, n_tick;
    int f_h, f_m, f_s, f_d, f_ev, f_adv, f_esecs;

    function automatic int hmap(input int h);
`ifdef TWELVE_HOUR_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
`else
        return h;
`endif
    endfunction

    function automatic int hpm(input int h);
`ifdef TWELVE_HOUR_EN
        return (h >= 12) ? 1 : 0;
`else
        return (h < 0) ? 1 : 0;
`endif
    endfunction

    always_comb begin
        n_t = m_t; n_ps = m_ps; n_due = 0; n_pend = m_pend; n_tick = 0;
        f_h = m_t / 3600; f_m = (m_t / 60) % 60; f_s = m_t % 60;
        f_d = plus ? 1 : -1;
        f_ev = ((select == 3'd1 || select == 3'd2 || select == 3'd4) && (plus != minus)) ? 1 : 0;
        f_adv = (m_due != 0 || m_pend != 0) ? 1 : 0;
        f_esecs = (f_ev != 0 && select == 3'd1) ? 1 : 0;
        if (run && m_ps == CLK_HZ - 1 && f_esecs == 0) n_due = 1;
        if (f_esecs != 0) n_ps = 0;
        else if (run) n_ps = (m_ps + 1) % CLK_HZ;
        if (f_ev != 0) begin
            if (select == 3'd1) f_s = (f_s + f_d + 60) % 60;
            if (select == 3'd2) f_m = (f_m + f_d + 60) % 60;
            if (select == 3'd4) f_h = (f_h + f_d + 24) % 24;
            n_t = f_h * 3600 + f_m * 60 + f_s;
            n_pend = f_adv;
        end else if (f_adv != 0) begin
            n_t = (m_t + 1) % 86400;
            n_pend = 0;
            n_tick = 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t <= 0; m_ps <= 0; m_due <= 0; m_pend <= 0; m_tick <= 0;
        end else begin
            m_t <= n_t; m_ps <= n_ps; m_due <= n_due; m_pend <= n_pend; m_tick <= n_tick;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_secs", int'(secs), m_t % 60);
        chk("cyc_mins", int'(mins), (m_t / 60) % 60);
        chk("cyc_hours", int'(hours), hmap(m_t / 3600));
        chk("cyc_pm", int'(pm), hpm(m_t / 3600));
        chk("cyc_tick", int'(tick_1hz), m_tick);
        if (tick_1hz) tick_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0; select = 3'b000; plus = 1'b0; minus = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic pulse(input logic [2:0] sel, input logic p, input logic m);
        select = sel; plus = p; minus = m;
        step(1);
        select = 3'b000; plus = 1'b0; minus = 1'b0;
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk({name, "_h"}, int'(hours), hmap(h));
        chk({name, "_m"}, int'(mins), m);
        chk({name, "_s"}, int'(secs), s);
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; select = 3'b000; plus = 1'b0; minus = 1'b0;
        step(3);
        chk_time("reset", 0, 0, 0);
        chk("reset_tick", int'(tick_1hz), 0);
        chk("reset_pm", int'(pm), 0);

        // Free run: wrap at edge 10, first second at edge 11, second at edge 21.
        reset_n = 1'b1;
        run = 1'b1;
        tick_cnt = 0;
        step(11);
        chk("run_s1", int'(secs), 1);
        step(10);
        chk("run_s2", int'(secs), 2);
        step(4);
        chk_time("run25", 0, 0, 2);
        chk("run25_ticks", tick_cnt, 2);

        // Hours edit on the wrap cycle, then again while pending.
        do_reset();
        run = 1'b1;
        step(10);
        select = 3'b100; plus = 1'b1;
        step(1);
        chk_time("edtick1", 1, 0, 0);
        step(1);
        chk_time("edtick2", 2, 0, 0);
        select = 3'b000; plus = 1'b0;
        step(1);
        chk_time("edtick3", 2, 0, 1);
        chk("edtick3_tick", int'(tick_1hz), 1);

        // Preload 23:59:59 and roll over.
        do_reset();
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b010, 1'b0, 1'b1);
        pulse(3'b001, 1'b0, 1'b1);
        chk_time("pre", 23, 59, 59);
        chk("pre_pm", int'(pm), hpm(23));
        run = 1'b1;
        tick_cnt = 0;
        step(11);
        chk_time("roll", 0, 0, 0);
        chk("roll_tick", int'(tick_1hz), 1);
        step(1);
        chk("roll_ticks", tick_cnt, 1);
        run = 1'b0;

        // Minutes wrap both ways, then invalid edits.
        pulse(3'b010, 1'b0, 1'b1);
        chk_time("mdec", 0, 59, 0);
        pulse(3'b010, 1'b1, 1'b0);
        chk_time("minc", 0, 0, 0);
        pulse(3'b010, 1'b1, 1'b1);
        pulse(3'b011, 1'b1, 1'b0);
        pulse(3'b000, 1'b0, 1'b1);
        chk_time("inval", 0, 0, 0);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        pulse(3'b100, 1'b0, 1'b1);
        chk_time("h13", 13, 0, 0);
        chk("h13_pm", int'(pm), hpm(13));

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] sel_tab [8];
            sel_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b000, 3'b011, 3'b111};
            reset_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            run = ($urandom_range(0, 7) != 0);
            select = sel_tab[$urandom_range(0, 7)];
            plus = ($urandom_range(0, 5) == 0);
            minus = ($urandom_range(0, 7) == 0);
            step(1);
        end

        // Async reset mid-count clears everything without waiting for a clock.
        reset_n = 1'b1; select = 3'b000; plus = 1'b0; minus = 1'b0; run = 1'b1;
        pulse(3'b010, 1'b1, 1'b0);
        step(25);
        reset_n = 1'b0;
        #2;
        chk_time("arst", 0, 0, 0);
        chk("arst_tick", int'(tick_1hz), 0);
        chk("arst_pm", int'(pm), 0);
        step(2);
        reset_n = 1'b1;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
